// File: rtl/instr_fetch.sv
// instr_fetch: RV64 instruction-fetch stage.
// Holds the PC, issues single-outstanding requests to instruction memory and
// presents each fetched word to decode over a valid/ready handshake.
// Redirects from execute flush the held or in-flight instruction.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect targets
// enter a FAULT state instead of being aligned down).
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [63:0] PC,
  output logic [63:0] PCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        FetchFault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;  // address of the word being fetched
  logic [63:0] tgt_q, tgt_d;            // redirect target saved while draining
  logic [63:0] pc_q, pc_d;              // PC of the presented (or faulting) word
  logic [31:0] instr_q, instr_d;

  logic [63:0] redir_pc;   // redirect target after alignment policy
  logic [63:0] tgt_nxt;    // drain target including a same-cycle redirect
  logic        redir_bad;  // redirect target is misaligned and must trap
  logic        nxt_bad;    // drain target is misaligned and must trap
  logic        xfer;

`ifdef MISALIGN_TRAP_EN
  assign redir_pc  = RedirectPC;
  assign redir_bad = |RedirectPC[1:0];
  assign nxt_bad   = |tgt_nxt[1:0];
`else
  // Without the trap, targets are silently aligned down to a word boundary.
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^RedirectPC[1:0];
  assign redir_pc  = {RedirectPC[63:2], 2'b00};
  assign redir_bad = 1'b0;
  assign nxt_bad   = 1'b0;
`endif

  assign xfer    = imem_req && imem_ack;
  assign tgt_nxt = Redirect ? redir_pc : tgt_q;

  // Next-state logic: fetch/drain/present/fault sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tgt_d      = tgt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          if (Redirect) begin
            // Returned word is stale; drop it and refetch at the target.
            if (redir_bad) begin
              state_d = S_FAULT;
              pc_d    = redir_pc;
            end else begin
              fetch_pc_d = redir_pc;
            end
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = S_VALID;
          end
        end else if (Redirect) begin
          // Address must stay stable until the memory acks, so park the target.
          tgt_d   = redir_pc;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        tgt_d = tgt_nxt;
        if (xfer) begin
          if (nxt_bad) begin
            state_d = S_FAULT;
            pc_d    = tgt_nxt;
          end else begin
            fetch_pc_d = tgt_nxt;
            state_d    = S_FETCH;
          end
        end
      end
      S_VALID: begin
        if (Redirect) begin
          if (redir_bad) begin
            state_d = S_FAULT;
            pc_d    = redir_pc;
          end else begin
            fetch_pc_d = redir_pc;
            state_d    = S_FETCH;
          end
        end else if (InstrReady) begin
          fetch_pc_d = pc_q + 64'd4;
          state_d    = S_FETCH;
        end
      end
      S_FAULT: begin
        if (Redirect) begin
          if (redir_bad) begin
            pc_d = redir_pc;
          end else begin
            fetch_pc_d = redir_pc;
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      tgt_q      <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tgt_q      <= tgt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  // Outputs are forced to their reset values while reset is held so the
  // first reset cycle is clean even before the registers have been cleared.
  assign imem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign imem_addr  = fetch_pc_q;
  assign InstrValid = !reset && (state_q == S_VALID);
  assign Instr      = InstrValid ? instr_q : NOP_INSTR;
  assign PC         = reset ? RESET_PC : pc_q;
  assign PCPlus4    = PC + 64'd4;
`ifdef MISALIGN_TRAP_EN
  assign FetchFault = !reset && (state_q == S_FAULT);
`else
  assign FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected memory addresses and presented
// instructions are queued as stimulus is applied and popped by monitors.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [63:0] PC;
  logic [63:0] PCPlus4;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        FetchFault;

  instr_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .FetchFault(FetchFault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
  logic [63:0] addr_q[$];
  exp_t        ins_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          wait_n = 0;
  int          cnt = 0;
  logic        vprev = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    if (a == 64'h4) return 32'h0031_00B3;
    return {a[29:0], 2'b11} ^ 32'h0F00_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [63:0] a);
    exp_t e;
    e.pc  = a;
    e.ins = mem_word(a);
    return e;
  endfunction

  // Memory model: acks after wait_n request cycles.
  assign imem_ack   = imem_req && (cnt >= wait_n);
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clk) begin
    if (reset || (imem_req && imem_ack)) cnt <= 0;
    else if (imem_req) cnt <= cnt + 1;
  end

  // Monitors: completed memory transfers and new instruction presentations.
  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      if (addr_q.size() == 0) chk("addr_unexpected", imem_addr, 64'hDEAD_BEEF_DEAD_BEEF);
      else chk("imem_addr", imem_addr, addr_q.pop_front());
    end
    if (InstrValid && !vprev) begin
      if (ins_q.size() == 0) chk("valid_unexpected", PC, 64'hDEAD_BEEF_DEAD_BEEF);
      else begin
        exp_t e;
        e = ins_q.pop_front();
        chk("pres_pc", PC, e.pc);
        chk("pres_instr", {32'h0, Instr}, {32'h0, e.ins});
      end
    end
    vprev <= InstrValid;
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (InstrValid) return;
    end
    chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1; InstrReady = 1'b1; Redirect = 1'b0; RedirectPC = 64'h0;
    // Reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", {63'h0, imem_req}, 64'd0);
      chk("rst_valid", {63'h0, InstrValid}, 64'd0);
      chk("rst_instr", {32'h0, Instr}, 64'h13);
      chk("rst_pc", PC, 64'h0);
      chk("rst_pc4", PCPlus4, 64'h4);
      chk("rst_fault", {63'h0, FetchFault}, 64'd0);
    end
    addr_q.push_back(64'h0); addr_q.push_back(64'h4); addr_q.push_back(64'h8);
    ins_q.push_back(mk(64'h0)); ins_q.push_back(mk(64'h4)); ins_q.push_back(mk(64'h8));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("first_req", {63'h0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'h0);
    wait_valid("pc0");
    @(posedge clk); #1 InstrReady = 1'b0;
    wait_valid("pc4");
    // Stall in VALID for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      chk("hold_instr", {32'h0, Instr}, 64'h0031_00B3);
      chk("hold_pc", PC, 64'h4);
      chk("hold_req", {63'h0, imem_req}, 64'd0);
      @(negedge clk);
    end
    #1 InstrReady = 1'b1;
    @(posedge clk); #1 InstrReady = 1'b0;
    @(negedge clk);
    chk("ready_req", {63'h0, imem_req}, 64'd1);
    chk("ready_addr", imem_addr, 64'h8);
    wait_valid("pc8");

    // Delayed ack with two redirects while the request is outstanding.
    #1 wait_n = 3;
    addr_q.push_back(64'hC); addr_q.push_back(64'h200);
    ins_q.push_back(mk(64'h200));
    InstrReady = 1'b1;
    @(posedge clk); #1 InstrReady = 1'b0; Redirect = 1'b1; RedirectPC = 64'h100;
    @(negedge clk); chk("drain_addr0", imem_addr, 64'hC);
    @(posedge clk); #1 RedirectPC = 64'h200;
    @(negedge clk); chk("drain_addr1", imem_addr, 64'hC);
    @(posedge clk); #1 Redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drain_addr", imem_addr, 64'hC);
      chk("drain_valid", {63'h0, InstrValid}, 64'd0);
    end
    @(negedge clk);
    chk("redir_addr", imem_addr, 64'h200);
    chk("redir_valid", {63'h0, InstrValid}, 64'd0);
    wait_valid("pc200");

    // Redirect has priority over ready.
    #1 wait_n = 0;
    addr_q.push_back(64'h40); ins_q.push_back(mk(64'h40));
    InstrReady = 1'b1; Redirect = 1'b1; RedirectPC = 64'h40;
    @(posedge clk); #1 InstrReady = 1'b0; Redirect = 1'b0;
    @(negedge clk); chk("prio_addr", imem_addr, 64'h40);
    wait_valid("pc40");

    // PC + 4 wraps at the top of the address space.
    #1 addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); ins_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC));
    Redirect = 1'b1; RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #1 Redirect = 1'b0;
    wait_valid("pctop");
    chk("wrap_pc4", PCPlus4, 64'h0);
    #1 addr_q.push_back(64'h0); ins_q.push_back(mk(64'h0));
    InstrReady = 1'b1;
    @(posedge clk); #1 InstrReady = 1'b0;
    @(negedge clk); chk("wrap_addr", imem_addr, 64'h0);
    wait_valid("pcwrap");

    // Reset while draining abandons the transaction.
    #1 wait_n = 5; Redirect = 1'b1; RedirectPC = 64'h300;
    @(posedge clk); #1 RedirectPC = 64'h400;
    @(posedge clk); #1 Redirect = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("drst_req", {63'h0, imem_req}, 64'd0);
    chk("drst_valid", {63'h0, InstrValid}, 64'd0);
    @(posedge clk); #1 reset = 1'b0; wait_n = 0;
    addr_q.push_back(64'h0); ins_q.push_back(mk(64'h0));
    @(negedge clk);
    chk("drst_addr", imem_addr, 64'h0);
    chk("drst_req1", {63'h0, imem_req}, 64'd1);
    chk("drst_valid1", {63'h0, InstrValid}, 64'd0);
    wait_valid("pcrst");

    // Misaligned redirect target.
`ifdef MISALIGN_TRAP_EN
    #1 Redirect = 1'b1; RedirectPC = 64'h102;
    @(posedge clk); #1 Redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fault_flag", {63'h0, FetchFault}, 64'd1);
      chk("fault_pc", PC, 64'h102);
      chk("fault_req", {63'h0, imem_req}, 64'd0);
      chk("fault_valid", {63'h0, InstrValid}, 64'd0);
    end
    #1 addr_q.push_back(64'h200); ins_q.push_back(mk(64'h200));
    Redirect = 1'b1; RedirectPC = 64'h200;
    @(posedge clk); #1 Redirect = 1'b0;
    @(negedge clk);
    chk("fault_clr", {63'h0, FetchFault}, 64'd0);
    chk("fault_addr", imem_addr, 64'h200);
    wait_valid("pcfix");
`else
    #1 addr_q.push_back(64'h100); ins_q.push_back(mk(64'h100));
    Redirect = 1'b1; RedirectPC = 64'h102;
    @(posedge clk); #1 Redirect = 1'b0;
    @(negedge clk);
    chk("align_addr", imem_addr, 64'h100);
    wait_valid("pcalign");
    chk("nofault", {63'h0, FetchFault}, 64'd0);
`endif

    repeat (2) @(negedge clk);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("ins_q_empty", 64'(ins_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the sequential RV64 core; produces the `Instr` word that the decode stage consumes.
- Holds the 64-bit PC and issues single-outstanding requests to instruction memory.
- Presents each fetched word with its PC to decode over a valid/ready handshake.
- Accepts PC redirects (taken branch / jump) from execute, discarding in-flight or held instructions.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC fetched first after reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, value driven on `Instr` when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held with stable `imem_addr` until accepted
- imem_addr  out  64  byte address of requested word
- imem_ack  in  1  memory response; transfer completes in a cycle with `imem_req` && `imem_ack`
- imem_rdata  in  32  instruction word, valid when `imem_ack`=1
- Instr  out  32  instruction to decode
- PC  out  64  address of `Instr`
- PCPlus4  out  64  PC + 4 (mod 2^64)
- InstrValid  out  1  `Instr`/`PC` valid
- InstrReady  in  1  decode accepts `Instr` this cycle
- Redirect  in  1  load new PC, flush current instruction
- RedirectPC  in  64  redirect target
- FetchFault  out  1  misaligned-target fault (optional feature; tied 0 when disabled)

Behaviour:
- Reset (synchronous, active-high), outputs during and right after:
  - `PC`=RESET_PC, `PCPlus4`=RESET_PC+4, `Instr`=NOP_INSTR, `InstrValid`=0, `imem_req`=0, `FetchFault`=0.
  - State forced to FETCH, pending target = RESET_PC.
  - Any outstanding memory transaction is abandoned; imem shares `reset`.
  - First cycle after reset deasserts: `imem_req`=1, `imem_addr`=RESET_PC.
- FETCH state:
  - `imem_req`=1, `imem_addr`=fetch_pc.
  - On `imem_ack` without `Redirect`: latch `Instr`<=`imem_rdata`, `PC`<=fetch_pc; `InstrValid`=1 from the next cycle; go to VALID.
  - On `imem_ack` with `Redirect`: drop the data, fetch_pc<=RedirectPC, stay in FETCH (new address on `imem_addr` next cycle).
  - On `Redirect` without `imem_ack`: save the target, go to DRAIN. The address may not change mid-transaction.
- DRAIN state:
  - `imem_req`=1, `imem_addr` keeps the old address.
  - A further `Redirect` overwrites the saved target (last wins).
  - On `imem_ack`: discard data, fetch_pc<=saved target, go to FETCH.
- VALID state:
  - `InstrValid`=1; `Instr`, `PC`, `PCPlus4` held stable; `imem_req`=0.
  - `Redirect` (priority over `InstrReady`): `InstrValid`=0 next cycle, fetch_pc<=RedirectPC, go to FETCH.
  - Else if `InstrReady`: fetch_pc<=PC+4, `InstrValid`=0 next cycle, go to FETCH.
  - Else hold.
- Latency and throughput:
  - Ack cycle to `InstrValid`: 1 cycle.
  - Accept cycle to next `imem_req`: 1 cycle.
  - With zero-wait memory: one instruction per 2 cycles minimum.
- Outputs when `InstrValid`=0: `Instr`=NOP_INSTR; `PC` keeps its last value.
- Arithmetic: PC+4 wraps 64'hFFFF_FFFF_FFFF_FFFC -> 64'h0, no flag.
- Redirect to the currently held PC is still a flush plus refetch.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A `Redirect` with `RedirectPC[1:0]`!=0 is not fetched; enter FAULT state. In DRAIN, FAULT is entered after the pending ack.
  - In FAULT: `FetchFault`=1, `PC`=faulting target, `InstrValid`=0, `imem_req`=0.
  - Exit only by reset or an aligned `Redirect` (go to FETCH). A misaligned `Redirect` while in FAULT updates `PC`.
- Undefined: `RedirectPC[1:0]` forced to 2'b00 (align down); `FetchFault` constant 0.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory, `InstrReady`=1 -> `imem_addr` sequence 0x0, 0x4, 0x8; `InstrValid` pulses every 2 cycles with PC 0x0, 0x4, 0x8 and matching `imem_rdata`.
- `InstrReady`=0 for 5 cycles in VALID -> `Instr`=0x003100B3 and `PC`=0x4 held, `imem_req`=0 throughout; fetch of 0x8 issued 1 cycle after ready.
- `imem_ack` delayed 3 cycles, `Redirect` to 0x100 in cycle 1, then to 0x200 in cycle 2 -> `imem_addr` stays at the old address until ack; data dropped; next request to 0x200; no `InstrValid` for the dropped word.
- `Redirect`+`InstrReady` both high in VALID with `RedirectPC`=0x40 -> next fetch 0x40, not PC+4.
- PC=0xFFFF_FFFF_FFFF_FFFC accepted -> next `imem_addr`=0x0. Reset asserted during DRAIN -> next request at RESET_PC, `InstrValid`=0.
- `Redirect` to 0x102:
  - With MISALIGN_TRAP_EN: `FetchFault`=1, `PC`=0x102, no request; then `Redirect` to 0x200 clears the fault and fetches 0x200.
  - Without: fetch at 0x100.
